// File: rtl/tft_timing_pkg.sv
// rtl/tft_timing_pkg.sv - 480x272 TFT timing constants, FSM state type and RGB565 colours
package tft_timing_pkg;

   localparam int TFT_H_SYNC  = 41;
   localparam int TFT_H_BACK  = 2;
   localparam int TFT_H_VALID = 480;
   localparam int TFT_H_FRONT = 2;
   localparam int TFT_H_TOTAL = TFT_H_SYNC + TFT_H_BACK + TFT_H_VALID + TFT_H_FRONT;

   localparam int TFT_V_SYNC  = 10;
   localparam int TFT_V_BACK  = 2;
   localparam int TFT_V_VALID = 272;
   localparam int TFT_V_FRONT = 2;
   localparam int TFT_V_TOTAL = TFT_V_SYNC + TFT_V_BACK + TFT_V_VALID + TFT_V_FRONT;

   localparam int TFT_H_START = TFT_H_SYNC + TFT_H_BACK;
   localparam int TFT_V_START = TFT_V_SYNC + TFT_V_BACK;

   localparam logic [9:0] NO_REQ = 10'h3FF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [15:0] BLACK   = 16'h0000;
   localparam logic [15:0] RED     = 16'hF800;
   localparam logic [15:0] GREEN   = 16'h07E0;
   localparam logic [15:0] BLUE    = 16'h001F;
   localparam logic [15:0] YELLOW  = 16'hFFE0;
   localparam logic [15:0] CYAN    = 16'h07FF;
   localparam logic [15:0] MAGENTA = 16'hF81F;
   localparam logic [15:0] WHITE   = 16'hFFFF;

endpackage

// File: rtl/tft_timing_gen_if.sv
// rtl/tft_timing_gen_if.sv - pixel request/return bus between the timing generator and a pixel source
interface tft_timing_gen_if;
   import tft_timing_pkg::*;

   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic [15:0] pix_data;

   modport master (output pix_x, output pix_y, input pix_data);
   modport slave  (input pix_x, input pix_y, output pix_data);

endinterface

// File: rtl/tft_hv_cnt.sv
// rtl/tft_hv_cnt.sv - horizontal/vertical raster counters, held at zero while disabled
module tft_hv_cnt
   import tft_timing_pkg::*;
#(
   parameter int H_TOTAL = TFT_H_TOTAL,
   parameter int V_TOTAL = TFT_V_TOTAL
) (
   input  logic       tft_clk,
   input  logic       sys_rst_n,
   input  logic       en,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       frame_end
);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

   logic line_end;

   assign line_end  = (h_cnt == H_LAST);
   assign frame_end = line_end && (v_cnt == V_LAST);

   always_ff @(posedge tft_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         h_cnt <= 10'd0;
         v_cnt <= 10'd0;
      end else if (!en) begin
         h_cnt <= 10'd0;
         v_cnt <= 10'd0;
      end else if (line_end) begin
         h_cnt <= 10'd0;
         v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 10'd1;
      end
   end

endmodule

// File: rtl/tft_timing_gen.sv
// rtl/tft_timing_gen.sv - TFT raster timing with frame-aligned run/drain control; TFT_FRAME_CNT_EN adds frame_cnt
module tft_timing_gen
   import tft_timing_pkg::*;
#(
   parameter int H_SYNC  = TFT_H_SYNC,
   parameter int H_BACK  = TFT_H_BACK,
   parameter int H_VALID = TFT_H_VALID,
   parameter int H_FRONT = TFT_H_FRONT,
   parameter int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT,
   parameter int V_SYNC  = TFT_V_SYNC,
   parameter int V_BACK  = TFT_V_BACK,
   parameter int V_VALID = TFT_V_VALID,
   parameter int V_FRONT = TFT_V_FRONT,
   parameter int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT
) (
   input  logic        tft_clk,
   input  logic        sys_rst_n,
   input  logic        disp_en,
   tft_timing_gen_if.master pix,
   output logic [15:0] rgb_tft,
   output logic        hsync,
   output logic        vsync,
   output logic        tft_de,
   output logic        tft_clk_out,
   output logic        tft_bl,
   output logic        frame_start,
   output logic        busy
`ifdef TFT_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam logic [9:0] HS_END    = 10'(H_SYNC);
   localparam logic [9:0] VS_END    = 10'(V_SYNC);
   localparam logic [9:0] H_ACT_BEG = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] H_ACT_END = 10'(H_SYNC + H_BACK + H_VALID);
   localparam logic [9:0] H_REQ_BEG = 10'(H_SYNC + H_BACK - 1);
   localparam logic [9:0] H_REQ_END = 10'(H_SYNC + H_BACK + H_VALID - 1);
   localparam logic [9:0] V_ACT_BEG = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] V_ACT_END = 10'(V_SYNC + V_BACK + V_VALID);

   state_t     state;
   logic       busy_q;
   logic       run;
   logic       frame_end;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       v_win;
   logic       active;
   logic       data_req;

   assign run = (state == RUN) || (state == DRAIN);

   tft_hv_cnt #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL)
   ) u_hv_cnt (
      .tft_clk   (tft_clk),
      .sys_rst_n (sys_rst_n),
      .en        (run),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .frame_end (frame_end)
   );

   // Stops only at the last pixel of a frame; DRAIN lets the current frame finish.
   always_ff @(posedge tft_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state  <= IDLE;
         busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (disp_en) begin
                  state  <= RUN;
                  busy_q <= 1'b1;
               end
            end
            RUN: begin
               if (!disp_en) begin
                  if (frame_end) begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     state  <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (frame_end) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else if (disp_en) begin
                  state  <= RUN;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign v_win    = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
   assign active   = run && v_win && (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
   // Request leads active by one clock to absorb the source's read latency.
   assign data_req = run && v_win && (h_cnt >= H_REQ_BEG) && (h_cnt < H_REQ_END);

   assign pix.pix_x = data_req ? (h_cnt - H_REQ_BEG) : NO_REQ;
   assign pix.pix_y = data_req ? (v_cnt - V_ACT_BEG) : NO_REQ;

   assign hsync       = run && (h_cnt < HS_END);
   assign vsync       = run && (v_cnt < VS_END);
   assign tft_de      = active;
   assign rgb_tft     = active ? pix.pix_data : BLACK;
   assign tft_clk_out = tft_clk;
   assign frame_start = (state == RUN) && (h_cnt == 10'd0) && (v_cnt == 10'd0);
   assign busy        = busy_q;
   assign tft_bl      = busy_q;

`ifdef TFT_FRAME_CNT_EN
   always_ff @(posedge tft_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         frame_cnt <= 16'd0;
      end else if (run && frame_end) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tft_timing_gen.sv
// tb/tb_tft_timing_gen.sv - directed bench for tft_timing_gen with a shortened vertical raster
module tb_tft_timing_gen;
   import tft_timing_pkg::*;

   localparam int HT    = 525;
   localparam int VT    = 13;
   localparam int FRAME = HT * VT;

   logic        tft_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        disp_en = 1'b0;
   logic [15:0] rgb_tft;
   logic        hsync, vsync, tft_de, tft_clk_out, tft_bl, frame_start, busy;
`ifdef TFT_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   int errors = 0;
   int checks = 0;
   int t, mism, first_bad, idle_bad;
   int vs_cnt, de_cnt, red_cnt, first_req, first_de, hs_low, fs_cnt, last_fs;
   logic [9:0] first_req_x, first_req_y;

   tft_timing_gen_if pif ();

   always #5 tft_clk = ~tft_clk;

   always @(posedge tft_clk) pif.pix_data <= (pif.pix_x < 10'd48) ? RED : BLUE;

   tft_timing_gen #(
      .V_SYNC (3), .V_BACK (2), .V_VALID (6), .V_FRONT (2), .V_TOTAL (13)
   ) dut (
      .tft_clk     (tft_clk),
      .sys_rst_n   (sys_rst_n),
      .disp_en     (disp_en),
      .pix         (pif),
      .rgb_tft     (rgb_tft),
      .hsync       (hsync),
      .vsync       (vsync),
      .tft_de      (tft_de),
      .tft_clk_out (tft_clk_out),
      .tft_bl      (tft_bl),
      .frame_start (frame_start),
      .busy        (busy)
`ifdef TFT_FRAME_CNT_EN
      ,
      .frame_cnt   (frame_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      mism = 0; first_bad = -1; vs_cnt = 0; de_cnt = 0; red_cnt = 0;
      first_req = -1; first_de = -1; hs_low = -1; fs_cnt = 0; last_fs = -1;
   endtask

   // Expected raster values from the cycle index t since the first RUN cycle.
   task automatic compare(input logic exp_busy);
      int h, v;
      logic ehs, evs, ede, efs, req;
      logic [9:0]  epx, epy;
      logic [15:0] ergb;
      h    = t % HT;
      v    = (t / HT) % VT;
      ehs  = (h < 41);
      evs  = (v < 3);
      ede  = (h >= 43) && (h < 523) && (v >= 5) && (v < 11);
      ergb = ede ? (((h - 43) < 48) ? RED : BLUE) : 16'h0000;
      req  = (h >= 42) && (h < 522) && (v >= 5) && (v < 11);
      epx  = req ? 10'(h - 42) : 10'h3FF;
      epy  = req ? 10'(v - 5) : 10'h3FF;
      efs  = (h == 0) && (v == 0);
      if ({hsync, vsync, tft_de, frame_start, busy, tft_bl, pif.pix_x, pif.pix_y, rgb_tft} !==
          {ehs, evs, ede, efs, exp_busy, exp_busy, epx, epy, ergb}) begin
         if (mism == 0) first_bad = t;
         mism++;
      end
      if (vsync) vs_cnt++;
      if (tft_de) de_cnt++;
      if (tft_de && rgb_tft == RED) red_cnt++;
      if (first_req < 0 && pif.pix_x != 10'h3FF) begin
         first_req = t; first_req_x = pif.pix_x; first_req_y = pif.pix_y;
      end
      if (first_de < 0 && tft_de) first_de = t;
      if (hs_low < 0 && !hsync) hs_low = t;
      if (frame_start) begin fs_cnt++; last_fs = t; end
   endtask

   task automatic run_phase(input int n, input logic exp_busy);
      for (int i = 0; i < n; i++) begin
         @(negedge tft_clk);
         compare(exp_busy);
         t++;
      end
   endtask

   task automatic idle_phase(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge tft_clk);
         if (hsync || vsync || tft_de || frame_start || busy || tft_bl || rgb_tft != 16'h0 ||
             pif.pix_x != 10'h3FF || pif.pix_y != 10'h3FF || dut.h_cnt != 10'd0 || dut.v_cnt != 10'd0)
            idle_bad++;
      end
   endtask

   initial begin
      repeat (3) @(negedge tft_clk);
      chk("rst_pix_x", 32'(pif.pix_x), 32'h3FF);
      chk("rst_pix_y", 32'(pif.pix_y), 32'h3FF);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_bl", 32'(tft_bl), 0);
      chk("rst_sync", 32'({hsync, vsync, tft_de, frame_start}), 0);
      chk("rst_rgb", 32'(rgb_tft), 0);

      sys_rst_n = 1'b1;
      idle_bad = 0;
      idle_phase(1000);
      chk("idle_hold_1000", 32'(idle_bad), 0);

      // First run: three full frames.
      disp_en = 1'b1;
      t = 0;
      clear_stats();
      run_phase(FRAME, 1'b1);
      chk("frame1_model_mism", 32'(mism), 0);
      chk("frame1_first_bad", 32'(first_bad), 32'hFFFF_FFFF);
      chk("hsync_width", 32'(hs_low), 41);
      chk("first_req_time", 32'(first_req), 2667);
      chk("first_req_x", 32'(first_req_x), 0);
      chk("first_req_y", 32'(first_req_y), 0);
      chk("first_de_time", 32'(first_de), 2668);
      chk("vsync_clocks", 32'(vs_cnt), 1575);
      chk("de_per_frame", 32'(de_cnt), 2880);
      chk("red_per_frame", 32'(red_cnt), 288);
      chk("frame1_fs_cnt", 32'(fs_cnt), 1);

      run_phase(2 * FRAME + 1, 1'b1);
      chk("frames23_model_mism", 32'(mism), 0);
      chk("fs_cnt_3frames", 32'(fs_cnt), 4);
      chk("fs_period", 32'(last_fs), 32'(3 * FRAME));
`ifdef TFT_FRAME_CNT_EN
      chk("frame_cnt_3", 32'(frame_cnt), 3);
`endif

      // Drop disp_en mid-frame at line 7; the frame must complete before IDLE.
      run_phase(7 * HT + 99, 1'b1);
      disp_en = 1'b0;
      run_phase(1, 1'b1);
      chk("drain_state", 32'(dut.state), 32'(DRAIN));
      run_phase(FRAME - 7 * HT - 101, 1'b1);
      chk("drain_model_mism", 32'(mism), 0);
      @(negedge tft_clk);
      chk("drain_end_state", 32'(dut.state), 32'(IDLE));
      chk("drain_end_bl", 32'(tft_bl), 0);
      chk("drain_end_busy", 32'(busy), 0);
      chk("drain_end_fs", 32'(frame_start), 0);
`ifdef TFT_FRAME_CNT_EN
      chk("frame_cnt_drain", 32'(frame_cnt), 4);
`endif
      idle_bad = 0;
      idle_phase(20);
      chk("idle_after_drain", 32'(idle_bad), 0);

      // Second run: re-enable during DRAIN; the frame period must not stretch.
      disp_en = 1'b1;
      t = 0;
      clear_stats();
      run_phase(3 * HT, 1'b1);
      disp_en = 1'b0;
      run_phase(1, 1'b1);
      chk("run2_drain_state", 32'(dut.state), 32'(DRAIN));
      run_phase(5 * HT - 1, 1'b1);
      disp_en = 1'b1;
      run_phase(FRAME - 8 * HT + 1, 1'b1);
      chk("run2_model_mism", 32'(mism), 0);
      chk("run2_fs_cnt", 32'(fs_cnt), 2);
      chk("run2_no_gap", 32'(last_fs), 32'(FRAME));
      chk("run2_state", 32'(dut.state), 32'(RUN));

      // Asynchronous reset in the middle of an active line.
      run_phase(6 * HT + 300, 1'b1);
      chk("pre_reset_mism", 32'(mism), 0);
      #2;
      sys_rst_n = 1'b0;
      disp_en   = 1'b0;
      #1;
      chk("arst_de", 32'(tft_de), 0);
      chk("arst_rgb", 32'(rgb_tft), 0);
      chk("arst_pix_x", 32'(pif.pix_x), 32'h3FF);
      chk("arst_pix_y", 32'(pif.pix_y), 32'h3FF);
      chk("arst_busy_bl", 32'({busy, tft_bl}), 0);
      chk("arst_sync", 32'({hsync, vsync, frame_start}), 0);
      chk("arst_clk_out_low", 32'(tft_clk_out), 0);
`ifdef TFT_FRAME_CNT_EN
      chk("arst_frame_cnt", 32'(frame_cnt), 0);
`endif
      @(posedge tft_clk);
      #1;
      chk("arst_clk_out_high", 32'(tft_clk_out), 1);
      chk("arst_hold_busy", 32'(busy), 0);
      @(negedge tft_clk);
      sys_rst_n = 1'b1;
      idle_bad = 0;
      idle_phase(10);
      chk("idle_after_reset", 32'(idle_bad), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
